// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and default widths
package spi_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_SS     = 4;
    localparam int DEF_DIV_WIDTH  = 4;
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SETUP  = 2'd1;
    localparam state_t XFER   = 2'd2;
    localparam state_t FINISH = 2'd3;
    // {cpol, cpha}
    typedef logic [1:0] mode_t;
    localparam mode_t MODE0 = 2'b00;
    localparam mode_t MODE1 = 2'b01;
    localparam mode_t MODE2 = 2'b10;
    localparam mode_t MODE3 = 2'b11;
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period tick generator with SCK edge parity and edge count
module spi_clkgen #(
    parameter int DIV_WIDTH = 4,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [CNT_WIDTH-1:0] edges,
    output logic                 tick,
    output logic                 leading,
    output logic                 edges_done
);
    logic [DIV_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] num;
    assign tick = en && cnt == div;
    // the tick about to happen is odd-numbered while the count so far is even
    assign leading = ~num[0];
    assign edges_done = num >= edges;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            num <= '0;
        end else if (clr) begin
            cnt <= '0;
            num <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_WIDTH'(1);
            num <= num + CNT_WIDTH'(tick);
        end
    end
endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi: multi-slave, four-mode SPI master with variable frame length and SS hold
module spi_master_multi import spi_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_SS     = DEF_NUM_SS,
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
    localparam int SEL_WIDTH = NUM_SS > 1 ? $clog2(NUM_SS) : 1,
    localparam int LEN_WIDTH = $clog2(DATA_WIDTH + 1),
    localparam int CNT_WIDTH = $clog2(2 * DATA_WIDTH + 3)
) (
    input  logic                  spi_clk_i,
    input  logic                  spi_rst_i,
    input  logic                  spi_start_i,
    input  logic [SEL_WIDTH-1:0]  spi_ss_sel_i,
    input  logic                  spi_cpol_i,
    input  logic                  spi_cpha_i,
    input  logic                  spi_msbfirst_i,
    input  logic [DIV_WIDTH-1:0]  spi_div_i,
    input  logic [LEN_WIDTH-1:0]  spi_len_i,
    input  logic                  spi_hold_i,
    input  logic [DATA_WIDTH-1:0] spi_data_i,
    output logic [DATA_WIDTH-1:0] spi_data_o,
    output logic                  spi_busy_o,
    output logic                  spi_done_o,
    input  logic                  MISO,
    output logic                  MOSI,
    output logic                  SCK_SPI,
    output logic [NUM_SS-1:0]     SS
);
    localparam logic [LEN_WIDTH-1:0] FULL = LEN_WIDTH'(DATA_WIDTH);

    state_t                state;
    mode_t                 mode;
    logic                  msb, hold, cpol, cpha;
    logic [DIV_WIDTH-1:0]  div;
    logic [LEN_WIDTH-1:0]  len, len_in, tx_pos, rx_pos;
    logic [DATA_WIDTH-1:0] tx, rx, data;
    logic [NUM_SS-1:0]     ss;
    logic                  sck, mosi, busy, done;
    logic                  start, tick, leading, edges_done, sck_edge, sample, shift;

    // bit k of the frame in transmit order
    function automatic logic pick(input logic [DATA_WIDTH-1:0] w, input logic m,
                                  input logic [LEN_WIDTH-1:0] n, input logic [LEN_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] s;
        s = w >> (m ? n - k - LEN_WIDTH'(1) : k);
        return s[0];
    endfunction

    assign start    = state == IDLE && spi_start_i;
    assign len_in   = (spi_len_i == '0 || spi_len_i > FULL) ? FULL : spi_len_i;
    assign cpha     = mode == MODE1 || mode == MODE3;
    assign cpol     = mode == MODE2 || mode == MODE3;
    assign sck_edge = tick && state != FINISH && !edges_done;
    assign sample   = sck_edge && (leading ^ cpha);
    assign shift    = sck_edge && !(leading ^ cpha) && tx_pos < len;

    spi_clkgen #(.DIV_WIDTH(DIV_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_clkgen (
        .clk        (spi_clk_i),
        .rst_n      (spi_rst_i),
        .clr        (start),
        .en         (state != IDLE),
        .div        (div),
        .edges      (CNT_WIDTH'({len, 1'b0})),
        .tick       (tick),
        .leading    (leading),
        .edges_done (edges_done)
    );

    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            state  <= IDLE;
            mode   <= MODE0;
            msb    <= 1'b0;
            hold   <= 1'b0;
            div    <= '0;
            len    <= '0;
            tx     <= '0;
            rx     <= '0;
            data   <= '0;
            tx_pos <= '0;
            rx_pos <= '0;
            ss     <= '1;
            sck    <= 1'b0;
            mosi   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state  <= SETUP;
                mode   <= {spi_cpol_i, spi_cpha_i};
                msb    <= spi_msbfirst_i;
                hold   <= spi_hold_i;
                div    <= spi_div_i;
                len    <= len_in;
                tx     <= spi_data_i;
                rx     <= '0;
                rx_pos <= '0;
                tx_pos <= spi_cpha_i ? '0 : LEN_WIDTH'(1);
                busy   <= 1'b1;
                ss     <= ~(NUM_SS'(1) << spi_ss_sel_i);
                sck    <= spi_cpol_i;
                if (!spi_cpha_i)
                    mosi <= pick(spi_data_i, spi_msbfirst_i, len_in, '0);
            end else if (tick) begin
                if (state == SETUP)
                    state <= XFER;
                else if (state == XFER && edges_done) begin
                    state <= FINISH;
                    sck   <= cpol;
                end else if (state == FINISH) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    data  <= rx;
                    if (!hold)
                        ss <= '1;
                end
            end
            if (sck_edge)
                sck <= ~sck;
            if (sample) begin
                rx     <= msb ? {rx[DATA_WIDTH-2:0], MISO} : rx | (DATA_WIDTH'(MISO) << rx_pos);
                rx_pos <= rx_pos + LEN_WIDTH'(1);
            end
            if (shift) begin
                mosi   <= pick(tx, msb, len, tx_pos);
                tx_pos <= tx_pos + LEN_WIDTH'(1);
            end
        end
    end

    assign spi_data_o = data;
    assign spi_busy_o = busy;
    assign spi_done_o = done;
    assign MOSI       = mosi;
    assign SCK_SPI    = sck;
    assign SS         = ss;
endmodule
